// File: rtl/serial_eq_cmp_pkg.sv
// serial_eq_cmp_pkg: shared state encoding and counter sizing for serial_eq_cmp.
package serial_eq_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit counter width; must be able to hold the value width itself.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_eq_cmp_if.sv
// serial_eq_cmp_if: request/result bundle of serial_eq_cmp.
// gt/lt exist only when SERIAL_EQ_CMP_MAG_EN is defined.
interface serial_eq_cmp_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             eq;
`ifdef SERIAL_EQ_CMP_MAG_EN
    logic             gt;
    logic             lt;

    modport master (output start, a, b, input busy, done, eq, gt, lt);
    modport slave  (input start, a, b, output busy, done, eq, gt, lt);
`else
    modport master (output start, a, b, input busy, done, eq);
    modport slave  (input start, a, b, output busy, done, eq);
`endif
endinterface

// File: rtl/serial_eq_cmp_eq1.sv
// eq1: 1-bit equality cell.
module eq1 (
    input  logic a,
    input  logic b,
    output logic eq
);
    assign eq = ~(a ^ b);
endmodule

// File: rtl/serial_eq_cmp.sv
// serial_eq_cmp: bit-serial WIDTH-bit equality comparator using one eq1 cell.
// Optional unsigned magnitude outputs gt/lt under SERIAL_EQ_CMP_MAG_EN.
module serial_eq_cmp
    import serial_eq_cmp_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    serial_eq_cmp_if.slave  bus
);
    localparam int unsigned CW = cnt_width(WIDTH);

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sh_a, sh_b;
    logic             acc;
    logic             eq_q;
    logic             bit_a, bit_b, cell_eq;
    logic             last_bit;

    assign bit_a    = MSB_FIRST ? sh_a[WIDTH-1] : sh_a[0];
    assign bit_b    = MSB_FIRST ? sh_b[WIDTH-1] : sh_b[0];
    assign last_bit = (cnt == CW'(WIDTH - 1));

    eq1 u_eq1 (
        .a  (bit_a),
        .b  (bit_b),
        .eq (cell_eq)
    );

`ifdef SERIAL_EQ_CMP_MAG_EN
    logic decided, decided_nx;
    logic gt_acc, lt_acc, gt_nx, lt_nx;
    logic gt_q, lt_q;

    // MSB-first keeps the first mismatch; LSB-first lets each later mismatch overwrite.
    always_comb begin
        gt_nx      = gt_acc;
        lt_nx      = lt_acc;
        decided_nx = decided;
        if (!cell_eq && (!MSB_FIRST || !decided)) begin
            gt_nx      = bit_a;
            lt_nx      = bit_b;
            decided_nx = 1'b1;
        end
    end

    assign bus.gt = gt_q;
    assign bus.lt = lt_q;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state and status decode.
    always_comb begin
        state_nx = state;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) state_nx = SHIFT;
            end
            SHIFT: begin
                bus.busy = 1'b1;
                if (last_bit) state_nx = DONE;
            end
            DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture, serial scan, accumulation and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            sh_a <= '0;
            sh_b <= '0;
            acc  <= 1'b0;
            eq_q <= 1'b0;
`ifdef SERIAL_EQ_CMP_MAG_EN
            decided <= 1'b0;
            gt_acc  <= 1'b0;
            lt_acc  <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
`endif
        end else if (state == IDLE) begin
            if (bus.start) begin
                sh_a <= bus.a;
                sh_b <= bus.b;
                cnt  <= '0;
                acc  <= 1'b1;
`ifdef SERIAL_EQ_CMP_MAG_EN
                decided <= 1'b0;
                gt_acc  <= 1'b0;
                lt_acc  <= 1'b0;
`endif
            end
        end else if (state == SHIFT) begin
            sh_a <= MSB_FIRST ? (sh_a << 1) : (sh_a >> 1);
            sh_b <= MSB_FIRST ? (sh_b << 1) : (sh_b >> 1);
            cnt  <= cnt + 1'b1;
            acc  <= acc & cell_eq;
`ifdef SERIAL_EQ_CMP_MAG_EN
            decided <= decided_nx;
            gt_acc  <= gt_nx;
            lt_acc  <= lt_nx;
`endif
            if (last_bit) begin
                eq_q <= acc & cell_eq;
`ifdef SERIAL_EQ_CMP_MAG_EN
                gt_q <= gt_nx;
                lt_q <= lt_nx;
`endif
            end
        end
    end

    assign bus.eq = eq_q;

endmodule

// File: tb/tb_serial_eq_cmp.sv
// tb_serial_eq_cmp: directed bench for serial_eq_cmp (WIDTH=8 MSB/LSB-first, WIDTH=1).
// gt/lt are checked only when SERIAL_EQ_CMP_MAG_EN is defined.
module tb_serial_eq_cmp;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serial_eq_cmp_if #(.WIDTH(8)) bus_m ();
    serial_eq_cmp_if #(.WIDTH(8)) bus_l ();
    serial_eq_cmp_if #(.WIDTH(1)) bus_1 ();

    serial_eq_cmp #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst_n(rst_n), .bus(bus_m));
    serial_eq_cmp #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst_n(rst_n), .bus(bus_l));
    serial_eq_cmp #(.WIDTH(1), .MSB_FIRST(1'b1)) dut_1 (.clk(clk), .rst_n(rst_n), .bus(bus_1));

    typedef struct {
        logic busy, done, eq, gt, lt;
    } obs_t;

    typedef struct {
        int         sel;
        logic [7:0] a, b;
        logic       eq, gt, lt;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    logic prev_eq[3];
    logic prev_gt[3];
    logic prev_lt[3];
    vec_t vecs[15];

    function automatic obs_t observe(input int sel);
        obs_t o;
        o = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        case (sel)
            0: begin
                o.busy = bus_m.busy; o.done = bus_m.done; o.eq = bus_m.eq;
`ifdef SERIAL_EQ_CMP_MAG_EN
                o.gt = bus_m.gt; o.lt = bus_m.lt;
`endif
            end
            1: begin
                o.busy = bus_l.busy; o.done = bus_l.done; o.eq = bus_l.eq;
`ifdef SERIAL_EQ_CMP_MAG_EN
                o.gt = bus_l.gt; o.lt = bus_l.lt;
`endif
            end
            default: begin
                o.busy = bus_1.busy; o.done = bus_1.done; o.eq = bus_1.eq;
`ifdef SERIAL_EQ_CMP_MAG_EN
                o.gt = bus_1.gt; o.lt = bus_1.lt;
`endif
            end
        endcase
        return o;
    endfunction

    task automatic drive(input int sel, input logic st, input logic [7:0] a, input logic [7:0] b);
        case (sel)
            0:       begin bus_m.start = st; bus_m.a = a;    bus_m.b = b;    end
            1:       begin bus_l.start = st; bus_l.a = a;    bus_l.b = b;    end
            default: begin bus_1.start = st; bus_1.a = a[0]; bus_1.b = b[0]; end
        endcase
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b required=%0b", name, act, exp);
        end
    endtask

    task automatic chk_mag(input string name, input obs_t o, input logic egt, input logic elt);
`ifdef SERIAL_EQ_CMP_MAG_EN
        chk({name, "_gt"}, o.gt, egt);
        chk({name, "_lt"}, o.lt, elt);
`endif
    endtask

    // One operation: start at the accepting edge T0, then sample #1 after edges T0..T0+W+1.
    task automatic run_op(input string tag, input int sel, input logic [7:0] a, input logic [7:0] b,
                          input logic eeq, input logic egt, input logic elt);
        int   w;
        obs_t o;
        w = (sel == 2) ? 1 : 8;
        @(negedge clk);
        drive(sel, 1'b1, a, b);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 8'($urandom), 8'($urandom));
        for (int j = 0; j <= w + 1; j++) begin
            o = observe(sel);
            chk($sformatf("%s_busy_j%0d", tag, j), o.busy, (j <= w));
            chk($sformatf("%s_done_j%0d", tag, j), o.done, (j == w));
            if (j < w) begin
                chk($sformatf("%s_hold_eq_j%0d", tag, j), o.eq, prev_eq[sel]);
                chk_mag($sformatf("%s_hold_j%0d", tag, j), o, prev_gt[sel], prev_lt[sel]);
            end else if (j == w) begin
                chk({tag, "_eq"}, o.eq, eeq);
                chk_mag(tag, o, egt, elt);
            end
            @(posedge clk);
            #1;
        end
        prev_eq[sel] = eeq;
        prev_gt[sel] = egt;
        prev_lt[sel] = elt;
    endtask

    task automatic chk_all_zero(input string tag);
        obs_t o;
        for (int s = 0; s < 3; s++) begin
            o = observe(s);
            chk($sformatf("%s_busy_s%0d", tag, s), o.busy, 1'b0);
            chk($sformatf("%s_done_s%0d", tag, s), o.done, 1'b0);
            chk($sformatf("%s_eq_s%0d", tag, s), o.eq, 1'b0);
            chk_mag($sformatf("%s_s%0d", tag, s), o, 1'b0, 1'b0);
        end
    endtask

    initial begin
        obs_t o;
        int   last_done;
        int   n_done;
        logic prev_done;

        vecs[0]  = '{0, 8'hA5, 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{0, 8'h80, 8'h7F, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{0, 8'h01, 8'h02, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{0, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{0, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1, 8'h80, 8'h7F, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1, 8'h01, 8'h02, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1, 8'hA5, 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1, 8'h02, 8'h01, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1, 8'h81, 8'h01, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1, 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{2, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{2, 8'h01, 8'h01, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{2, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{2, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};

        for (int s = 0; s < 3; s++) begin
            prev_eq[s] = 1'b0; prev_gt[s] = 1'b0; prev_lt[s] = 1'b0;
            drive(s, 1'b0, 8'h00, 8'h00);
        end

        // Reset held for 3 cycles, then idle with start low.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("idle");

        // Directed vector table.
        for (int i = 0; i < 15; i++)
            run_op($sformatf("v%0d", i), vecs[i].sel, vecs[i].a, vecs[i].b,
                   vecs[i].eq, vecs[i].gt, vecs[i].lt);

        // Start held high: accepted every WIDTH+2 cycles, operands scrambled while busy.
        @(negedge clk);
        drive(0, 1'b1, 8'h00, 8'h00);
        last_done = -1;
        n_done    = 0;
        prev_done = 1'b0;
        for (int k = 0; k < 45; k++) begin
            @(posedge clk);
            #1;
            o = observe(0);
            if (o.done) begin
                n_done++;
                chk($sformatf("hold_eq_k%0d", k), o.eq, 1'b1);
                chk_mag($sformatf("hold_k%0d", k), o, 1'b0, 1'b0);
                chk($sformatf("hold_first_k%0d", k), (last_done >= 0) ? ((k - last_done) == 10) : (k == 8), 1'b1);
                last_done = k;
            end
            if (prev_done) chk($sformatf("hold_pulse_k%0d", k), o.done, 1'b0);
            prev_done = o.done;
            @(negedge clk);
            if (o.busy) drive(0, 1'b1, 8'($urandom), 8'($urandom));
            else        drive(0, 1'b1, 8'h00, 8'h00);
        end
        chk("hold_done_count", (n_done == 4), 1'b1);
        drive(0, 1'b0, 8'h00, 8'h00);
        repeat (12) @(posedge clk);
        prev_eq[0] = 1'b1; prev_gt[0] = 1'b0; prev_lt[0] = 1'b0;

        // Reset in the middle of an FF vs 00 comparison.
        @(negedge clk);
        drive(0, 1'b1, 8'hFF, 8'h00);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 8'h00, 8'h00);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            o = observe(0);
            if (o.done) n_done++;
        end
        chk("midrst_no_done", (n_done == 0), 1'b1);
        for (int s = 0; s < 3; s++) begin
            prev_eq[s] = 1'b0; prev_gt[s] = 1'b0; prev_lt[s] = 1'b0;
        end
        run_op("after_rst", 0, 8'h3C, 8'h3C, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
